// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch/decode/execute sequencer that drives the PC register,
//            with an internal return-address stack for CALL/RET.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int AW          = 13,
    parameter int STACK_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          mem_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    input  logic          zero,
    output logic          mem_req,
    output logic          ir_write,
    output logic          pc_write,
    output logic [AW-1:0] pc_next,
    output logic          halted,
    output logic          stack_ovf,
    output logic          stack_unf,
    output logic [3:0]    sp
);

    localparam int             SPW  = $clog2(STACK_DEPTH + 1);
    localparam int             IW   = $clog2(STACK_DEPTH);
    localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRZ  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    state_t         state;
    state_t         state_nx;
    logic [SPW-1:0] sp_q;
    logic           ovf_q;
    logic           unf_q;
    logic [AW-1:0]  stack_mem [STACK_DEPTH];
    logic [AW-1:0]  pc_inc;
    logic [IW-1:0]  pop_idx;
    logic           push;
    logic           pop;
    logic           set_ovf;
    logic           set_unf;

    assign pc_inc  = pc + AW'(1);
    assign pop_idx = IW'(sp_q - SPW'(1));

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_next  = pc_inc;
        halted   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        unique case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                case (op)
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_next  = target;
                    end
                    OP_BRZ: begin
                        pc_write = 1'b1;
                        if (zero) pc_next = target;
                    end
                    OP_CALL: begin
                        if (sp_q != FULL) begin
                            push     = 1'b1;
                            pc_write = 1'b1;
                            pc_next  = target;
                        end else begin
                            set_ovf  = 1'b1;
                            state_nx = HALT;
                        end
                    end
                    OP_RET: begin
                        if (sp_q != '0) begin
                            pop      = 1'b1;
                            pc_write = 1'b1;
                            pc_next  = stack_mem[pop_idx];
                        end else begin
                            set_unf  = 1'b1;
                            state_nx = HALT;
                        end
                    end
                    OP_HALT: state_nx = HALT;
                    default: pc_write = 1'b1;
                endcase
            end
            HALT: halted = 1'b1;
        endcase
        // Hold every enable low while reset is asserted; fetch resumes on release.
        if (rst) begin
            mem_req  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            halted   = 1'b0;
            push     = 1'b0;
            pop      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (push)
                sp_q <= sp_q + SPW'(1);
            else if (pop)
                sp_q <= sp_q - SPW'(1);
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    // Stack contents need no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) stack_mem[sp_q[IW-1:0]] <= pc_inc;
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

    generate
        if (SPW >= 4) begin : g_sp_wide
            assign sp = sp_q[3:0];
        end else begin : g_sp_narrow
            assign sp = {{(4 - SPW){1'b0}}, sp_q};
        end
    endgenerate

endmodule
`default_nettype wire
